// File: rtl/z80_uart_tx_pkg.sv
// Shared types for the Z80 UART transmitter: serialiser states and status-byte bit positions.
package z80_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;

endpackage

// File: rtl/z80_uart_tx_fifo.sv
// Small synchronous byte FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module z80_uart_tx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    logic [7:0]       mem_q [2**FIFO_AW];
    logic [FIFO_AW:0] wp_q;
    logic [FIFO_AW:0] rp_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                     (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    // Both qualifiers use the pre-edge flags: a push into a full FIFO is lost even if a pop frees a slot.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rp_q[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q[FIFO_AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop_ok)  rp_q <= rp_q + 1'b1;
        end
    end

endmodule

// File: rtl/z80_uart_tx.sv
// Z80 I/O-mapped 8N1 UART transmitter: OUT to the data port queues a byte, IN from the status port polls it.
module z80_uart_tx
    import z80_uart_tx_pkg::*;
#(
    parameter int         CLK_DIV = 234,
    parameter int         FIFO_AW = 4,
    parameter logic [7:0] IO_BASE = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bus_io_req,
    input  logic       bus_write,
    input  logic [7:0] bus_address,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_en,
    output logic       uart_tx
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rdata_en_q;

    logic          hit;
    logic          wr_data;
    logic          rd_stat;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          baud_done;
    logic [7:0]    status;

    assign hit     = bus_io_req && (bus_address[7:1] == IO_BASE[7:1]);
    assign wr_data = hit && bus_write && !bus_address[0];
    assign rd_stat = hit && !bus_write && bus_address[0];

    z80_uart_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data),
        .wdata   (bus_wdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = (state_q != ST_IDLE);
        rdata_d            = rd_stat ? status : 8'h00;
    end

    assign baud_done = (baud_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    bit_d    = 3'd0;
                    baud_d   = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level is registered from the current state, so it trails the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        if (state_q == ST_START)     tx_d = 1'b0;
        else if (state_q == ST_DATA) tx_d = shift_q[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            rdata_q    <= 8'h00;
            rdata_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rd_stat;
        end
    end

    assign uart_tx      = tx_q;
    assign bus_rdata    = rdata_q;
    assign bus_rdata_en = rdata_en_q;

endmodule
